// File: rtl/saph_pixdecode.sv
// saph_pixdecode: unpacks framebuffer words (ARGB8888, RGB565, ARGB1555,
// GRAY8) into a stream of 32-bit ARGB colors, least-significant pixel first.
// A word is held until its last pixel is consumed. The next word can be
// accepted on that same edge, so back-to-back words flow without a bubble.

module saph_pixdecode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_fmt,
  input  logic [1:0]  in_npix,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_col,
  output logic        out_last
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  localparam logic [1:0] FMT_ARGB8888 = 2'd0;
  localparam logic [1:0] FMT_RGB565   = 2'd1;
  localparam logic [1:0] FMT_ARGB1555 = 2'd2;
  localparam logic [1:0] FMT_GRAY8    = 2'd3;

  // Widen a 5-bit channel to 8 bits by replicating its top bits into the low bits.
  function automatic logic [7:0] expand5(input logic [4:0] v);
    return {v, v[4:2]};
  endfunction

  // Widen a 6-bit channel to 8 bits by replicating its top bits into the low bits.
  function automatic logic [7:0] expand6(input logic [5:0] v);
    return {v, v[5:4]};
  endfunction

  // Index of the last pixel to emit. An npix of 0, or an npix larger than
  // the format holds, means the word is full.
  function automatic logic [1:0] calc_last_idx(input logic [1:0] fmt,
                                               input logic [1:0] npix);
    logic [2:0] ppw;
    logic [2:0] cnt;
    logic [2:0] cnt_m1;
    case (fmt)
      FMT_ARGB8888: ppw = 3'd1;
      FMT_RGB565:   ppw = 3'd2;
      FMT_ARGB1555: ppw = 3'd2;
      FMT_GRAY8:    ppw = 3'd4;
      default:      ppw = 3'd1;
    endcase
    if ((npix == 2'd0) || ({1'b0, npix} > ppw)) begin
      cnt = ppw;
    end else begin
      cnt = {1'b0, npix};
    end
    cnt_m1 = cnt - 3'd1;
    return cnt_m1[1:0];
  endfunction

  // Extract pixel idx of a packed word and convert it to ARGB8888.
  function automatic logic [31:0] decode_pixel(input logic [31:0] word,
                                               input logic [1:0]  fmt,
                                               input logic [1:0]  idx);
    logic [15:0] half;
    logic [7:0]  gray;
    logic [31:0] col;
    half = idx[0] ? word[31:16] : word[15:0];
    case (idx)
      2'd0:    gray = word[7:0];
      2'd1:    gray = word[15:8];
      2'd2:    gray = word[23:16];
      2'd3:    gray = word[31:24];
      default: gray = 8'h00;
    endcase
    case (fmt)
      FMT_ARGB8888: col = word;
      FMT_RGB565:   col = {8'hFF, expand5(half[15:11]), expand6(half[10:5]),
                           expand5(half[4:0])};
      FMT_ARGB1555: col = {(half[15] ? 8'hFF : 8'h00), expand5(half[14:10]),
                           expand5(half[9:5]), expand5(half[4:0])};
      FMT_GRAY8:    col = {8'hFF, gray, gray, gray};
      default:      col = 32'h0000_0000;
    endcase
    return col;
  endfunction

  state_t      state;
  state_t      state_next;
  logic [31:0] word;
  logic [31:0] word_next;
  logic [1:0]  fmt;
  logic [1:0]  fmt_next;
  logic        word_last;
  logic        word_last_next;
  logic [1:0]  last_idx;
  logic [1:0]  last_idx_next;
  logic [1:0]  idx;
  logic [1:0]  idx_next;
  logic [31:0] col_next;
  logic        out_last_next;

  logic        final_pix;
  logic        out_hs;
  logic        accept;
  logic [1:0]  new_last_idx;
  logic [1:0]  idx_inc;

  assign out_valid    = (state == ST_EMIT);
  assign final_pix    = (idx == last_idx);
  assign out_hs       = out_valid && out_ready;
  assign in_ready     = rst_n && (!out_valid || (out_ready && final_pix));
  assign accept       = in_valid && in_ready;
  assign new_last_idx = calc_last_idx(in_fmt, in_npix);
  assign idx_inc      = idx + 2'd1;

  // Next-state and next-output selection: accept a word, step to the next pixel, or go idle.
  always_comb begin
    state_next     = state;
    word_next      = word;
    fmt_next       = fmt;
    word_last_next = word_last;
    last_idx_next  = last_idx;
    idx_next       = idx;
    col_next       = out_col;
    out_last_next  = out_last;
    if (accept) begin
      state_next     = ST_EMIT;
      word_next      = in_data;
      fmt_next       = in_fmt;
      word_last_next = in_last;
      last_idx_next  = new_last_idx;
      idx_next       = 2'd0;
      col_next       = decode_pixel(in_data, in_fmt, 2'd0);
      out_last_next  = in_last && (new_last_idx == 2'd0);
    end else if (out_hs && !final_pix) begin
      idx_next      = idx_inc;
      col_next      = decode_pixel(word, fmt, idx_inc);
      out_last_next = word_last && (idx_inc == last_idx);
    end else if (out_hs) begin
      // Final pixel consumed with nothing new to take: drop valid, keep the color.
      state_next    = ST_IDLE;
      idx_next      = 2'd0;
      out_last_next = 1'b0;
    end else begin
      state_next = state;
    end
  end

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      word      <= 32'h0000_0000;
      fmt       <= 2'd0;
      word_last <= 1'b0;
      last_idx  <= 2'd0;
      idx       <= 2'd0;
      out_col   <= 32'h0000_0000;
      out_last  <= 1'b0;
    end else begin
      state     <= state_next;
      word      <= word_next;
      fmt       <= fmt_next;
      word_last <= word_last_next;
      last_idx  <= last_idx_next;
      idx       <= idx_next;
      out_col   <= col_next;
      out_last  <= out_last_next;
    end
  end

endmodule
